// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the stream_cipher / stream_decipher pair:
// the AES SBOX used as keystream table, the FSM state type and the
// keystream helper so both directions index the table identically.
package stream_cipher_pkg;

  typedef enum logic {
    IDLE = 1'b0,  // no key loaded yet, input side closed
    RUN  = 1'b1   // key loaded, bytes flow through
  } state_t;

  localparam int BYTE_W = 8;

  // AES forward SBOX, entry 0 first.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Keystream byte for position idx: the table is indexed by key+idx
  // in 8 bits, so the carry is dropped and the index wraps naturally.
  function automatic logic [7:0] keystream_byte(input logic [7:0] key_val,
                                                input logic [7:0] idx_val);
    logic [7:0] sum;
    sum = key_val + idx_val;
    return SBOX[sum];
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO used as the plaintext output buffer.
// The head entry is visible combinationally so a byte written at one
// edge is presented right after it; output reads as zero when empty.
// A push while full and a pop while empty are ignored.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [ADDR_W:0]    wr_ptr_reg;
  logic [ADDR_W:0]    rd_ptr_reg;
  logic [WIDTH-1:0]   mem_reg [DEPTH];
  logic [DEPTH-1:0]   wr_en;
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // One write enable per storage slot, decoded from the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_reg[ADDR_W-1:0] == ADDR_W'(gi));
  end

  // Pointer update; flush empties the buffer without touching storage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; cleared on reset so no stale byte survives it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_reg[i] <= '0;
      end else if (wr_en[i]) begin
        mem_reg[i] <= din;
      end
    end
  end

  assign dout = empty ? '0 : mem_reg[rd_ptr_reg[ADDR_W-1:0]];

endmodule

// File: rtl/stream_decipher.sv
// Byte-stream decipher: ptxt = ctxt XOR SBOX[key + idx], idx counting
// accepted bytes since the last key load. Results are buffered in a
// stream_fifo with valid/ready handshakes on both sides.
// Optional feature macro: STREAM_DECIPHER_RESYNC_EN adds din_sof, which
// restarts the keystream at idx 0 for the byte carrying it.
import stream_cipher_pkg::*;

module stream_decipher #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic [7:0] key,
  input  logic [7:0] ctxt_char,
  input  logic       din_valid,
`ifdef STREAM_DECIPHER_RESYNC_EN
  input  logic       din_sof,
`endif
  output logic       din_ready,
  output logic [7:0] ptxt_char,
  output logic       dout_valid,
  input  logic       dout_ready
);

  state_t     state_reg;
  logic [7:0] key_reg;
  logic [7:0] idx_reg;

  logic [7:0] idx_use;
  logic [7:0] idx_next;
  logic [7:0] ptxt;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  // Keystream position for the byte being accepted this cycle.
`ifdef STREAM_DECIPHER_RESYNC_EN
  assign idx_use = din_sof ? 8'd0 : idx_reg;
`else
  assign idx_use = idx_reg;
`endif
  assign idx_next = idx_use + 8'd1;

  assign ptxt = ctxt_char ^ keystream_byte(key_reg, idx_use);

  // A key load closes the input for its cycle, so a colliding input
  // byte is never accepted and never advances idx.
  assign din_ready  = (state_reg == RUN) && !fifo_full && !key_in;
  assign push       = din_valid && din_ready;
  assign dout_valid = !fifo_empty;
  assign pop        = dout_valid && dout_ready;

  // Control FSM with key register and keystream index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (key_in) begin
            state_reg <= RUN;
            key_reg   <= key;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          if (key_in) begin
            key_reg <= key;
            idx_reg <= '0;
          end else if (push) begin
            idx_reg <= idx_next;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Output buffer; a key load flushes anything still queued.
  stream_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (key_in),
    .push  (push),
    .din   (ptxt),
    .pop   (pop),
    .dout  (ptxt_char),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_stream_decipher.sv
// Self-checking bench for stream_decipher. A reference model holds the
// key/index/occupancy; expected plaintext is queued when a byte is
// accepted and compared when it reaches the FIFO head. The SBOX used by
// the model is computed from the GF(2^8) inverse and AES affine map.
// Define STREAM_DECIPHER_RESYNC_EN to also exercise din_sof.
module tb_stream_decipher;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic [7:0] key;
  logic [7:0] ctxt_char;
  logic       din_valid;
  logic       dout_ready;
  wire        din_ready;
  wire  [7:0] ptxt_char;
  wire        dout_valid;
`ifdef STREAM_DECIPHER_RESYNC_EN
  logic       din_sof;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] sb_q [$];
  bit         m_run;
  logic [7:0] m_key;
  logic [7:0] m_idx;
  bit         g_acc;

  stream_decipher #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key        (key),
    .ctxt_char  (ctxt_char),
    .din_valid  (din_valid),
`ifdef STREAM_DECIPHER_RESYNC_EN
    .din_sof    (din_sof),
`endif
    .din_ready  (din_ready),
    .ptxt_char  (ptxt_char),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[v] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  // One clock: compare DUT outputs with the model at the falling edge,
  // then advance the model at the rising edge and move 1 ns past it.
  task automatic tick();
    bit         exp_ready;
    bit         push;
    bit         pop;
    bit         sof;
    logic [7:0] ix;
    @(negedge clk);
    exp_ready = m_run && (sb_q.size() < DEPTH) && !key_in;
    checks++;
    if (din_ready !== exp_ready) begin
      errors++;
      $display("FAIL din_ready actual %b required %b", din_ready, exp_ready);
    end
    checks++;
    if (dout_valid !== (sb_q.size() != 0)) begin
      errors++;
      $display("FAIL dout_valid actual %b required %b", dout_valid, sb_q.size() != 0);
    end
    if (sb_q.size() != 0) begin
      checks++;
      if (ptxt_char !== sb_q[0]) begin
        errors++;
        $display("FAIL ptxt_char actual %02h required %02h", ptxt_char, sb_q[0]);
      end
    end
    g_acc = din_valid && din_ready;
    push  = din_valid && exp_ready && !rst;
    pop   = dout_ready && (sb_q.size() != 0);
    sof   = 1'b0;
`ifdef STREAM_DECIPHER_RESYNC_EN
    sof   = din_sof;
`endif
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0;
      m_key = 8'h00;
      m_idx = 8'h00;
      sb_q.delete();
    end else if (key_in) begin
      m_run = 1'b1;
      m_key = key;
      m_idx = 8'h00;
      sb_q.delete();
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (push) begin
        ix = sof ? 8'h00 : m_idx;
        sb_q.push_back(ctxt_char ^ sbox_m[8'(m_key + ix)]);
        m_idx = ix + 8'd1;
      end
    end
    #1;
  endtask

  task automatic load_key(input logic [7:0] k);
    key_in = 1'b1;
    key    = k;
    tick();
    key_in = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    din_valid = 1'b1;
    ctxt_char = b;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual %0d required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = 1'b0; key = 8'h00; ctxt_char = 8'h00;
    din_valid = 1'b0; dout_ready = 1'b0;
`ifdef STREAM_DECIPHER_RESYNC_EN
    din_sof = 1'b0;
`endif
    m_run = 1'b0; m_key = 8'h00; m_idx = 8'h00; sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready actual %b required 0", din_ready); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid actual %b required 0", dout_valid); end
    checks++;
    if (ptxt_char !== 8'h00) begin errors++; $display("FAIL reset_ptxt actual %02h required 00", ptxt_char); end
    tick();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_pre_key();
    din_valid = 1'b1;
    ctxt_char = 8'h55;
    dout_ready = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL pre_key actual ready=%b valid=%b required 0 0", din_ready, dout_valid);
      end
    end
    din_valid = 1'b0;
    $display("test_pre_key done");
  endtask

  task automatic test_vectors();
    dout_ready = 1'b1;
    load_key(8'h00);
    send(8'h63);
    checks++;
    if (dout_valid !== 1'b1 || ptxt_char !== 8'h00) begin
      errors++;
      $display("FAIL vec_key00 actual valid=%b ptxt=%02h required 1 00", dout_valid, ptxt_char);
    end
    tick();
    load_key(8'h41);
    send(8'hC2);
    checks++;
    if (ptxt_char !== 8'h41) begin
      errors++;
      $display("FAIL vec_key41 actual %02h required 41", ptxt_char);
    end
    tick();
    load_key(8'hFF);
    send(8'h16);
    checks++;
    if (ptxt_char !== 8'h00) begin
      errors++;
      $display("FAIL vec_keyFF_0 actual %02h required 00", ptxt_char);
    end
    send(8'h63);
    checks++;
    if (dout_valid !== 1'b1 || ptxt_char !== 8'h00) begin
      errors++;
      $display("FAIL vec_keyFF_1 actual valid=%b ptxt=%02h required 1 00", dout_valid, ptxt_char);
    end
    tick();
    $display("test_vectors done");
  endtask

  task automatic test_fill_drain();
    int         acc;
    logic [7:0] head;
    load_key(8'h5A);
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    acc = 0;
    repeat (6) begin
      ctxt_char = 8'($urandom);
      tick();
      if (g_acc) acc++;
    end
    checks++;
    if (acc != DEPTH) begin errors++; $display("FAIL fill_count actual %0d required %0d", acc, DEPTH); end
    head = sb_q[0];
    dout_ready = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass actual %b required 0", din_ready); end
    dout_ready = 1'b0;
    tick();
    checks++;
    if (ptxt_char !== head) begin errors++; $display("FAIL hold_stable actual %02h required %02h", ptxt_char, head); end
    drain();
    $display("test_fill_drain done");
  endtask

  task automatic test_key_flush();
    load_key(8'h33);
    dout_ready = 1'b0;
    send(8'h10); send(8'h20); send(8'h30);
    key_in    = 1'b1;
    key       = 8'h00;
    din_valid = 1'b1;
    ctxt_char = 8'hAA;
    tick();
    key_in    = 1'b0;
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL key_flush actual %b required 0", dout_valid); end
    dout_ready = 1'b1;
    send(8'h63);
    checks++;
    if (ptxt_char !== 8'h00) begin errors++; $display("FAIL key_idx0 actual %02h required 00", ptxt_char); end
    tick();
    $display("test_key_flush done");
  endtask

  task automatic test_back_to_back();
    int acc;
    load_key(8'($urandom));
    dout_ready = 1'b1;
    din_valid  = 1'b1;
    acc = 0;
    repeat (20) begin
      ctxt_char = 8'($urandom);
      tick();
      if (g_acc) acc++;
    end
    checks++;
    if (acc != 20) begin errors++; $display("FAIL throughput actual %0d required 20", acc); end
    repeat (320) begin
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      ctxt_char  = 8'($urandom);
      tick();
    end
    drain();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    load_key(8'h77);
    dout_ready = 1'b0;
    send(8'h01); send(8'h02);
    rst    = 1'b1;
    key_in = 1'b1;
    key    = 8'h12;
    tick();
    rst    = 1'b0;
    key_in = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid actual valid=%b ready=%b required 0 0", dout_valid, din_ready);
    end
    send(8'h44);
    $display("test_reset_mid done");
  endtask

`ifdef STREAM_DECIPHER_RESYNC_EN
  task automatic test_resync();
    logic [7:0] bytes [4];
    bit         sofs  [4];
    bytes = '{8'h63, 8'h7C, 8'h63, 8'h7C};
    sofs  = '{1'b0, 1'b0, 1'b1, 1'b0};
    load_key(8'h00);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_sof = sofs[i];
      send(bytes[i]);
      din_sof = 1'b0;
      checks++;
      if (ptxt_char !== 8'h00) begin
        errors++;
        $display("FAIL resync_%0d actual %02h required 00", i, ptxt_char);
      end
    end
    tick();
    $display("test_resync done");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_pre_key();
    test_vectors();
    test_fill_drain();
    test_key_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef STREAM_DECIPHER_RESYNC_EN
    test_resync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_decipher.md
STREAM_DECIPHER -- requirements
Module: stream_decipher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of output buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port key_in  input  1  key load strobe, samples key.
REQ-005 SHALL have port key  input  8  decryption key.
REQ-006 SHALL have port ctxt_char  input  8  ciphertext byte.
REQ-007 SHALL have port din_valid  input  1  ctxt_char valid.
REQ-008 SHALL have port din_ready  output  1  block can accept ctxt_char.
REQ-009 SHALL have port ptxt_char  output  8  recovered plaintext byte, FIFO head.
REQ-010 SHALL have port dout_valid  output  1  ptxt_char valid.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts ptxt_char.
REQ-012 SHALL have port din_sof  input  1  start-of-frame marker, present only with STREAM_DECIPHER_RESYNC_EN.

Function
REQ-013 SHALL implement FSM states IDLE (no key loaded) and RUN; IDLE->RUN on key_in, RUN->RUN on key_in, any->IDLE only on rst.
REQ-014 SHALL, on key_in, register key into key_q, clear the 8-bit index idx to 0 and flush the FIFO in the same cycle; key_in wins over a simultaneous input handshake, which is dropped.
REQ-015 SHALL drive din_ready = (state==RUN) && !fifo_full && !key_in.
REQ-016 SHALL, on din_valid && din_ready, compute ptxt = ctxt_char XOR SBOX[(key_q + idx) mod 256], push it into the FIFO and increment idx.
REQ-017 SHALL wrap idx from 255 to 0 and compute key_q+idx in 8 bits (carry discarded).
REQ-018 SHALL present a byte accepted at edge t on ptxt_char with dout_valid=1 after edge t when the FIFO was empty (1-cycle latency).
REQ-019 SHALL sustain one byte per cycle when dout_ready is held high.
REQ-020 SHALL drive dout_valid = !fifo_empty and pop on dout_valid && dout_ready.
REQ-021 SHALL hold ptxt_char stable while dout_valid=1 and dout_ready=0.
REQ-022 SHALL, with the FIFO full, keep din_ready low even if dout_ready=1; no pop-to-push bypass.
REQ-023 SHALL push and pop in the same cycle when non-full and non-empty, leaving occupancy unchanged.
REQ-024 SHALL give identical results to the team's stream_cipher for equal key and byte order; decryption equals encryption.

Reset
REQ-025 SHALL, on rst, set state=IDLE, idx=0, key_q=0, FIFO empty, din_ready=0, dout_valid=0, ptxt_char=0.
REQ-026 SHALL discard all buffered bytes when rst is asserted mid-stream; rst has priority over key_in.

Configuration
REQ-027 SHALL, with STREAM_DECIPHER_RESYNC_EN defined, decode an accepted byte with din_sof=1 at idx=0 and set idx=1 afterwards, without flushing the FIFO.
REQ-028 SHALL, without STREAM_DECIPHER_RESYNC_EN, omit din_sof, and idx advances only per REQ-016/017.

Structure
REQ-029 SHALL take the 256-entry AES SBOX constant and the FSM state enum from the shared package stream_cipher_pkg, which stream_cipher also uses.
REQ-030 SHALL instantiate one sub-module, stream_fifo (parameterised width 8, depth FIFO_DEPTH, synchronous active-high reset, full/empty flags).

Verification
REQ-031 SHALL check: key_in with key=0x00, ctxt_char=0x63 accepted -> ptxt_char=0x00, dout_valid=1 one cycle later.
REQ-032 SHALL check: key=0x41, ctxt_char=0xC2 as first byte -> ptxt_char=0x41 ('A'; SBOX[0x41]=0x83).
REQ-033 SHALL check: key=0xFF, two bytes 0x16 and 0x63 -> ptxt 0x00 then 0x00 (idx wrap through SBOX[0xFF], SBOX[0x00]).
REQ-034 SHALL check: dout_ready=0, continuous din_valid -> exactly FIFO_DEPTH=4 bytes accepted, din_ready=0 afterwards; raising dout_ready drains them in order.
REQ-035 SHALL check: din_valid before any key_in -> din_ready=0, nothing is output. Then key_in mid-stream with 3 bytes buffered -> dout_valid=0 next cycle and the next byte uses idx 0.
REQ-036 SHALL check, with STREAM_DECIPHER_RESYNC_EN defined: key=0x00, bytes 0x63, 0x7C, then 0x63 with din_sof=1 -> ptxt 0x00, 0x00, 0x00.
